serial_subtractor: RTL and testbench

// - Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first, using one full-subtractor cell and a borrow flop.
// - Inverse-direction companion to the combinational full-adder cell.
// - Used where area matters more than latency; sits behind any requester that drives a start/operand/done handshake.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Optional signed-overflow output ovf is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  ra;
  logic [WIDTH-1:0]  rb;
  logic [WIDTH-1:0]  res;
  logic              bin;
  logic [CW-1:0]     cnt;
  logic              d;
  logic              bout;
  logic [WIDTH-1:0]  res_next;
`ifdef SERIAL_SUB_OVF_EN
  logic              sa;
  logic              sb;
`endif

  // One full-subtractor cell working on the current LSB of the operand shift registers.
  always_comb begin
    d        = ra[0] ^ rb[0] ^ bin;
    bout     = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & bin);
    res_next = {d, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ra         <= '0;
      rb         <= '0;
      res        <= '0;
      bin        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
      sa         <= 1'b0;
      sb         <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            ra    <= a;
            rb    <= b;
            bin   <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            sa    <= a[WIDTH-1];
            sb    <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          res <= res_next;
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          bin <= bout;
          cnt <= cnt + CW'(1);
          // Results are captured from the last bit's cell outputs so they appear with done.
          if (cnt == LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= bout;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= (sa != sb) && (d != sa);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); checks ovf when
// SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_cmp;
  int n_err;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One operation with start pulsed for a single cycle; checks latency, busy length and results.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int cyc;
    int busyc;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busyc = 0;
    @(negedge clk);
    while (!done && cyc < 20) begin
      if (busy) busyc++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, cyc, 8);
    chk({tag, "_busy"}, busyc, 8);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo) $display("note: ovf not built");
`endif
    @(negedge clk);
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_hold"}, diff, ed);
  endtask

  initial begin
    int nd;
    int t;
    int t1;
    int t2;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       b1;
    logic       b2;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    rst = 1'b0;

    run_op("t5a_3c", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    run_op("t00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op("ta5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);

    // start during SHIFT is ignored
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h01;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    nd = 0; d1 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin nd++; d1 = diff; end
    end
    chk("ign_pulses", nd, 1);
    chk("ign_diff", d1, 8'h0F);

    // asynchronous reset mid-operation (previous diff 0F is nonzero)
    @(negedge clk);
    start = 1'b1; a = 8'h77; b = 8'h11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", diff, 0);
    chk("arst_borrow", borrow_out, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("arst_quiet", nd, 0);
    run_op("t09_04", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = 8'h03; b = 8'h01;
    @(posedge clk);
    #1;
    nd = 0; t = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0;
    while (t < 40 && nd < 2) begin
      @(negedge clk);
      t++;
      if (t == 1) begin a = 8'h01; b = 8'h03; end
      if (nd == 1 && t == t1 + 1) begin
        chk("b2b_done_drop", done, 0);
        start = 1'b0;
      end
      if (done) begin
        nd++;
        if (nd == 1) begin t1 = t; d1 = diff; b1 = borrow_out; end
        else begin t2 = t; d2 = diff; b2 = borrow_out; end
      end
    end
    start = 1'b0;
    chk("b2b_pulses", nd, 2);
    chk("b2b_spacing", t2 - t1, 9);
    chk("b2b_diff1", d1, 8'h02);
    chk("b2b_borrow1", b1, 0);
    chk("b2b_diff2", d2, 8'hFE);
    chk("b2b_borrow2", b2, 1);

`ifdef SERIAL_SUB_OVF_EN
    run_op("o80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("o7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op("o05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
